// File: rtl/fpmult_execute_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP multiplier execute stage.
// The slave modport is the multiplier's view; the master modport is the producer/consumer side.
interface fpmult_execute_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic             in_valid;
    logic             in_ready;
    logic             a_sign;
    logic [EXP_W-1:0] a_exp;
    logic [MAN_W-1:0] a_man;
    logic             b_sign;
    logic [EXP_W-1:0] b_exp;
    logic [MAN_W-1:0] b_man;
    logic             rnd_mode;
    logic             out_valid;
    logic             out_ready;
    logic             p_sign;
    logic [EXP_W-1:0] p_exp;
    logic [MAN_W-1:0] p_man;
    logic             flag_ovf;
    logic             flag_unf;
    logic             flag_inx;

    modport master (
        output in_valid, a_sign, a_exp, a_man, b_sign, b_exp, b_man, rnd_mode, out_ready,
        input  in_ready, out_valid, p_sign, p_exp, p_man, flag_ovf, flag_unf, flag_inx
    );

    modport slave (
        input  in_valid, a_sign, a_exp, a_man, b_sign, b_exp, b_man, rnd_mode, out_ready,
        output in_ready, out_valid, p_sign, p_exp, p_man, flag_ovf, flag_unf, flag_inx
    );
endinterface

// File: rtl/fpmult_execute_pipe.sv
// Three-stage FP multiplier execute pipe: split mantissa product over S1/S2, then
// normalise, round (RNE/RTZ) and saturate in S3 into registered outputs.
module fpmult_execute_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int SPLIT = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    fpmult_execute_pipe_if.slave bus
);

    localparam int MW1  = MAN_W + 1;
    localparam int HI_W = MAN_W - SPLIT + 1;
    localparam int PH_W = MW1 + HI_W;
    localparam int MP_W = 2 * MAN_W + 2;
    localparam int EW2  = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW2-1:0] BIAS_S  = EW2'(BIAS);
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);

    // Stall chain: a stage loads when its own slot is empty or being drained downstream.
    logic adv1, adv2, adv3;
    logic v1_q, v2_q, out_valid_q;

    assign adv3         = !out_valid_q | bus.out_ready;
    assign adv2         = !v2_q | adv3;
    assign adv1         = !v1_q | adv2;
    assign bus.in_ready = adv1;

    // ---------------- S1: high partial product and exponent sum ----------------
    logic [MW1-1:0]          ma_d, mb_d;
    logic [PH_W-1:0]         s1_ph_d;
    logic signed [EW2-1:0]   s1_esum_d;
    logic                    s1_z_d;

    assign ma_d      = {1'b1, bus.a_man};
    assign mb_d      = {1'b1, bus.b_man};
    assign s1_ph_d   = {{HI_W{1'b0}}, ma_d} * {{MW1{1'b0}}, mb_d[MAN_W:SPLIT]};
    assign s1_esum_d = $signed({2'b00, bus.a_exp}) + $signed({2'b00, bus.b_exp}) - BIAS_S;
    assign s1_z_d    = (bus.a_exp == '0) | (bus.b_exp == '0);

    logic                    s1_sign_q, s1_rnd_q, s1_z_q;
    logic signed [EW2-1:0]   s1_esum_q;
    logic [PH_W-1:0]         s1_ph_q;
    logic [MW1-1:0]          s1_ma_q;
    logic [SPLIT-1:0]        s1_mbl_q;

    // NOTE: datapath registers are reset as well, so every output reads 0 while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_rnd_q  <= 1'b0;
            s1_z_q    <= 1'b0;
            s1_esum_q <= '0;
            s1_ph_q   <= '0;
            s1_ma_q   <= '0;
            s1_mbl_q  <= '0;
        end else begin
            // NOTE: all state uses <= so every stage samples its predecessor's old value.
            if (adv1) v1_q <= bus.in_valid;
            if (adv1 && bus.in_valid) begin
                s1_sign_q <= bus.a_sign ^ bus.b_sign;
                s1_rnd_q  <= bus.rnd_mode;
                s1_z_q    <= s1_z_d;
                s1_esum_q <= s1_esum_d;
                s1_ph_q   <= s1_ph_d;
                s1_ma_q   <= ma_d;
                s1_mbl_q  <= mb_d[SPLIT-1:0];
            end
        end
    end

    // ---------------- S2: combine partial products ----------------
    logic [MP_W-1:0] s2_mp_d;

    assign s2_mp_d = (MP_W'(s1_ph_q) << SPLIT) + MP_W'(s1_ma_q) * MP_W'(s1_mbl_q);

    logic                  s2_sign_q, s2_rnd_q, s2_z_q;
    logic signed [EW2-1:0] s2_esum_q;
    logic [MP_W-1:0]       s2_mp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_q      <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_rnd_q  <= 1'b0;
            s2_z_q    <= 1'b0;
            s2_esum_q <= '0;
            s2_mp_q   <= '0;
        end else begin
            if (adv2) v2_q <= v1_q;
            if (adv2 && v1_q) begin
                s2_sign_q <= s1_sign_q;
                s2_rnd_q  <= s1_rnd_q;
                s2_z_q    <= s1_z_q;
                s2_esum_q <= s1_esum_q;
                s2_mp_q   <= s2_mp_d;
            end
        end
    end

    // ---------------- S3: normalise, round, saturate ----------------
    logic                  norm, g_bit, st_bit, inc;
    logic [MAN_W-1:0]      frac;
    logic [MAN_W:0]        frac_sum;
    logic signed [EW2-1:0] e_n, e_r;
    logic [EXP_W-1:0]      p_exp_d;
    logic [MAN_W-1:0]      p_man_d;
    logic                  ovf_d, unf_d, inx_d;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        norm     = s2_mp_q[MP_W-1];
        frac     = s2_mp_q[2*MAN_W-1:MAN_W];
        g_bit    = s2_mp_q[MAN_W-1];
        st_bit   = |s2_mp_q[MAN_W-2:0];
        e_n      = s2_esum_q;
        inc      = 1'b0;
        frac_sum = '0;
        e_r      = '0;
        p_exp_d  = '0;
        p_man_d  = '0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inx_d    = 1'b0;

        if (norm) begin
            frac   = s2_mp_q[2*MAN_W:MAN_W+1];
            g_bit  = s2_mp_q[MAN_W];
            st_bit = |s2_mp_q[MAN_W-1:0];
            e_n    = s2_esum_q + EW2'(1);
        end

        inc      = !s2_rnd_q & g_bit & (st_bit | frac[0]);
        frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
        // A rounding carry wraps the fraction to zero and bumps the exponent.
        e_r      = frac_sum[MAN_W] ? e_n + EW2'(1) : e_n;

        if (s2_z_q) begin
            p_exp_d = '0;
            p_man_d = '0;
        end else if (e_r >= EXP_MAX) begin
            p_exp_d = '1;
            ovf_d   = 1'b1;
            inx_d   = 1'b1;
        end else if (e_r[EW2-1] || e_r == '0) begin
            unf_d   = 1'b1;
            inx_d   = 1'b1;
        end else begin
            p_exp_d = e_r[EXP_W-1:0];
            p_man_d = frac_sum[MAN_W-1:0];
            inx_d   = g_bit | st_bit;
        end
    end

    logic             p_sign_q, ovf_q, unf_q, inx_q;
    logic [EXP_W-1:0] p_exp_q;
    logic [MAN_W-1:0] p_man_q;

    // Output registers only change on a fresh result, so they hold steady under stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            p_sign_q    <= 1'b0;
            p_exp_q     <= '0;
            p_man_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            if (adv3) out_valid_q <= v2_q;
            if (adv3 && v2_q) begin
                p_sign_q <= s2_sign_q;
                p_exp_q  <= p_exp_d;
                p_man_q  <= p_man_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
                inx_q    <= inx_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.p_sign    = p_sign_q;
    assign bus.p_exp     = p_exp_q;
    assign bus.p_man     = p_man_q;
    assign bus.flag_ovf  = ovf_q;
    assign bus.flag_unf  = unf_q;
    assign bus.flag_inx  = inx_q;

endmodule

// File: tb/tb_fpmult_execute_pipe.sv
// Randomised and directed bench for fpmult_execute_pipe against an arithmetic
// single-precision multiply reference, with backpressure, stall and reset scenarios.
module tb_fpmult_execute_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fpmult_execute_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fpmult_execute_pipe #(.EXP_W(8), .MAN_W(23), .SPLIT(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    logic [34:0] exp_q[$];
    logic [34:0] mon_w;
    logic [34:0] held;
    int          acc0, out0;
    bit          rand_done;
    logic [31:0] ra, rb;
    logic        rr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // {ovf, unf, inx, sign, exp, man}
    function automatic logic [34:0] dut_out();
        return {bus.flag_ovf, bus.flag_unf, bus.flag_inx, bus.p_sign, bus.p_exp, bus.p_man};
    endfunction

    // Reference: exact 48-bit product, then round by comparing the discarded remainder to half an ulp.
    function automatic logic [34:0] ref_mult(input logic [31:0] a, input logic [31:0] b, input logic rtz);
        logic            sign;
        longint unsigned ma, mb, p, q, rem, half;
        int              e, sh;
        bit              up;
        sign = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {3'b000, sign, 31'd0};
        ma = (64'd1 << 23) + 64'(a[22:0]);
        mb = (64'd1 << 23) + 64'(b[22:0]);
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end
        q    = p >> sh;
        rem  = p & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        up   = !rtz && (rem > half || (rem == half && q[0]));
        q    = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {3'b101, sign, 8'hFF, 23'd0};
        if (e <= 0)   return {3'b011, sign, 31'd0};
        return {2'b00, rem != 0, sign, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        int         m;
        m = int'($urandom_range(0, 9));
        case (m)
            0:       e = 8'd0;
            1:       e = 8'($urandom_range(200, 254));
            2:       e = 8'($urandom_range(1, 60));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Presents one operand pair at posedge+1 and returns at posedge+1 after it was accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic rtz, input logic [34:0] want);
        bit ok;
        ok           = 1'b0;
        bus.a_sign   = a[31];
        bus.a_exp    = a[30:23];
        bus.a_man    = a[22:0];
        bus.b_sign   = b[31];
        bus.b_exp    = b[30:23];
        bus.b_man    = b[22:0];
        bus.rnd_mode = rtz;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(want);
                n_acc++;
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_latency(input string tag);
        check({tag, "_c1"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_c2"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_c3"}, 64'(bus.out_valid), 64'd1);
    endtask

    // Scoreboard: a result transfers on the coming posedge when valid&ready at the negedge.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                mon_w = exp_q.pop_front();
                check("result", 64'(dut_out()), 64'(mon_w));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a_sign    = 1'b0;
        bus.a_exp     = '0;
        bus.a_man     = '0;
        bus.b_sign    = 1'b0;
        bus.b_exp     = '0;
        bus.b_man     = '0;
        bus.rnd_mode  = 1'b0;

        #1 rst = 1'b0;
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_outputs",   64'(dut_out()),     64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // 1.5 * 1.5 with exact 3-cycle latency
        send(32'h3FC00000, 32'h3FC00000, 1'b0, {3'b000, 32'h40100000});
        check_latency("lat");
        wait_drain("drain_basic");

        // Rounding tie, overflow, underflow and zero, back to back
        send(32'h3F800001, 32'h3FC00000, 1'b0, {3'b001, 32'h3FC00002});
        send(32'h3F800001, 32'h3FC00000, 1'b1, {3'b001, 32'h3FC00001});
        send(32'h7F000000, 32'h40000000, 1'b0, {3'b101, 32'h7F800000});
        send(32'h00800000, 32'h00800000, 1'b0, {3'b011, 32'h00000000});
        send(32'h00000000, 32'hC0000000, 1'b0, {3'b000, 32'h80000000});
        wait_drain("drain_corners");

        // Stall: five back-to-back ops with the consumer blocked
        bus.out_ready = 1'b0;
        acc0 = n_acc;
        out0 = n_out;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    ra = rand_op();
                    rb = rand_op();
                    rr = 1'($urandom);
                    send(ra, rb, rr, ref_mult(ra, rb, rr));
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                check("stall_accepted", 64'(n_acc - acc0), 64'd3);
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                check("stall_valid",    64'(bus.out_valid), 64'd1);
                held = dut_out();
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk); #1;
                    check("stall_hold", 64'(dut_out()), 64'(held));
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("drain_stall");
        check("stall_results", 64'(n_out - out0), 64'd5);

        // Random traffic with random backpressure and idle gaps
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 400; k++) begin
                    ra = rand_op();
                    rb = rand_op();
                    rr = 1'($urandom);
                    send(ra, rb, rr, ref_mult(ra, rb, rr));
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("drain_random");

        // Asynchronous reset with three ops in flight
        send(32'h3FC00000, 32'h3FC00000, 1'b0, {3'b000, 32'h40100000});
        send(32'h40400000, 32'h40400000, 1'b0, {3'b000, 32'h41100000});
        send(32'hBFC00000, 32'h40000000, 1'b0, {3'b000, 32'hC0400000});
        rst = 1'b0;
        #1;
        check("arst_valid",   64'(bus.out_valid), 64'd0);
        check("arst_outputs", 64'(dut_out()),     64'd0);
        exp_q.delete();
        @(negedge clk);
        check("arst_hold_valid", 64'(bus.out_valid), 64'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        send(32'h40400000, 32'h40000000, 1'b0, {3'b000, 32'h40C00000});
        check_latency("arst_lat");
        wait_drain("drain_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
